// File: rtl/fm_spy_ring.sv
// fm_spy_ring: single-clock spy ring buffer for the fast-monitoring path.
// Captures one selected channel into a circular memory. Capture runs either
// continuously or freezes a programmable number of words after a trigger.
// Readout is random access, or a ready/valid playback stream that runs once
// or loops.
// Ports:
//   clk_hs, rst_hs (async, active low)
//   ch_data/ch_valid/ch_sel : channel inputs and capture-channel select
//   mode/start/stop         : command interface (mode, start latched on accept)
//   trigger/post_trig       : freeze trigger and post-trigger word count
//   pb_len                  : playback length minus one
//   rd_en/rd_addr -> rd_data/rd_valid : random-access read, 1-cycle latency
//   pb_data/pb_valid/pb_ready         : playback stream
//   state/wr_ptr/wrapped/trig_seen/trig_addr : status
module fm_spy_ring #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int N_CH       = 4,
  parameter int POST_W     = 10,
  parameter int SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                       clk_hs,
  input  logic                       rst_hs,
  input  logic [N_CH*DATA_WIDTH-1:0] ch_data,
  input  logic [N_CH-1:0]            ch_valid,
  input  logic [SEL_W-1:0]           ch_sel,
  input  logic [1:0]                 mode,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       trigger,
  input  logic [POST_W-1:0]          post_trig,
  input  logic [ADDR_WIDTH-1:0]      pb_len,
  input  logic                       rd_en,
  input  logic [ADDR_WIDTH-1:0]      rd_addr,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_valid,
  output logic [DATA_WIDTH-1:0]      pb_data,
  output logic                       pb_valid,
  input  logic                       pb_ready,
  output logic [2:0]                 state,
  output logic [ADDR_WIDTH-1:0]      wr_ptr,
  output logic                       wrapped,
  output logic                       trig_seen,
  output logic [ADDR_WIDTH-1:0]      trig_addr
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [2:0] S_IDLE = 3'd0, S_CAP = 3'd1, S_POST = 3'd2,
                         S_FROZEN = 3'd3, S_PB = 3'd4;
  localparam logic [ADDR_WIDTH-1:0] TOP = '1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [2:0]            state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] pb_len_q, pb_len_d;
  logic [POST_W-1:0]     post_cnt_q, post_cnt_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic                  wrapped_q, wrapped_d;
  logic                  trig_seen_q, trig_seen_d;
  logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rdat_q;
  // Playback: issue pointer, one read in flight, 2-entry skid holding words
  // already read so backpressure never loses a word.
  logic [ADDR_WIDTH-1:0] pb_addr_q, pb_addr_d;
  logic                  iss_done_q, iss_done_d;
  logic                  infl_q, infl_d, infl_last_q, infl_last_d;
  logic [1:0][DATA_WIDTH-1:0] sk_data_q, sk_data_d;
  logic [1:0]            sk_last_q, sk_last_d;
  logic [1:0]            sk_cnt_q, sk_cnt_d;

  logic [DATA_WIDTH-1:0] cap_word;
  logic                  cap_vld, we, re, pop, issue;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [1:0]            occ, cnt_tmp;

  // Mux by compare so a select beyond N_CH-1 simply captures nothing.
  always_comb begin
    cap_word = '0;
    cap_vld  = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel_q == SEL_W'(k)) begin
        cap_word = ch_data[k*DATA_WIDTH +: DATA_WIDTH];
        cap_vld  = ch_valid[k];
      end
    end
  end

  assign we  = ((state_q == S_CAP) || (state_q == S_POST)) && cap_vld;
  assign pop = (sk_cnt_q != 2'd0) && pb_ready;
  assign occ = sk_cnt_q + {1'b0, infl_q};

  always_comb begin
    state_d     = state_q;     mode_d      = mode_q;
    sel_d       = sel_q;       pb_len_d    = pb_len_q;
    post_cnt_d  = post_cnt_q;  wr_ptr_d    = wr_ptr_q;
    wrapped_d   = wrapped_q;   trig_seen_d = trig_seen_q;
    trig_addr_d = trig_addr_q; pb_addr_d   = pb_addr_q;
    iss_done_d  = iss_done_q;  infl_d      = 1'b0;
    infl_last_d = infl_last_q; sk_data_d   = sk_data_q;
    sk_last_d   = sk_last_q;   sk_cnt_d    = sk_cnt_q;
    cnt_tmp     = sk_cnt_q;    issue       = 1'b0;
    re          = 1'b0;        raddr       = rd_addr;
    rd_valid_d  = 1'b0;

    if (state_q != S_PB) begin
      re         = rd_en;
      rd_valid_d = rd_en;
    end

    if (we) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (wr_ptr_q == TOP) wrapped_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_FROZEN: begin
        if (stop) begin
          if (state_q == S_FROZEN) state_d = S_IDLE;
        end else if (start) begin
          mode_d   = mode;
          sel_d    = ch_sel;
          pb_len_d = pb_len;
          if (!mode[1]) begin
            wr_ptr_d    = '0;
            wrapped_d   = 1'b0;
            trig_seen_d = 1'b0;
            state_d     = S_CAP;
          end else begin
            pb_addr_d  = '0;
            iss_done_d = 1'b0;
            state_d    = S_PB;
          end
        end
      end
      S_CAP: begin
        if ((mode_q == 2'd1) && trigger) begin
          trig_seen_d = 1'b1;
          trig_addr_d = wr_ptr_q;
          post_cnt_d  = post_trig;
          state_d     = (stop || (post_trig == '0)) ? S_FROZEN : S_POST;
        end else if (stop) begin
          state_d = S_FROZEN;
        end
      end
      S_POST: begin
        if (we) begin
          post_cnt_d = post_cnt_q - 1'b1;
          if (post_cnt_q == POST_W'(1)) state_d = S_FROZEN;
        end
        if (stop) state_d = S_FROZEN;
      end
      S_PB: begin
        if (stop) begin
          state_d  = S_IDLE;
          sk_cnt_d = 2'd0;
        end else begin
          // Occupancy (skid + in flight) never exceeds 2.
          issue = !iss_done_q && (pop || (occ <= 2'd1));
          if (issue) begin
            re          = 1'b1;
            raddr       = pb_addr_q;
            infl_d      = 1'b1;
            infl_last_d = (pb_addr_q == pb_len_q);
            pb_addr_d   = (pb_addr_q == pb_len_q) ? '0 : pb_addr_q + 1'b1;
            if ((pb_addr_q == pb_len_q) && !mode_q[0]) iss_done_d = 1'b1;
          end
          if (pop) begin
            sk_data_d[0] = sk_data_q[1];
            sk_last_d[0] = sk_last_q[1];
            cnt_tmp      = sk_cnt_q - 1'b1;
          end
          if (infl_q) begin
            sk_data_d[cnt_tmp[0]] = rdat_q;
            sk_last_d[cnt_tmp[0]] = infl_last_q;
            cnt_tmp               = cnt_tmp + 1'b1;
          end
          sk_cnt_d = cnt_tmp;
          if (pop && sk_last_q[0] && !mode_q[0]) begin
            state_d  = S_IDLE;
            sk_cnt_d = 2'd0;
            infl_d   = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_hs) begin
    if (we) mem[wr_ptr_q] <= cap_word;
  end

  // Read register is shared by readout and playback; read-first on collision.
  always_ff @(posedge clk_hs or negedge rst_hs) begin
    if (!rst_hs)  rdat_q <= '0;
    else if (re)  rdat_q <= mem[raddr];
  end

  always_ff @(posedge clk_hs or negedge rst_hs) begin
    if (!rst_hs) begin
      state_q <= S_IDLE;  mode_q <= '0;      sel_q <= '0;
      pb_len_q <= '0;     post_cnt_q <= '0;  wr_ptr_q <= '0;
      wrapped_q <= 1'b0;  trig_seen_q <= 1'b0; trig_addr_q <= '0;
      rd_valid_q <= 1'b0; pb_addr_q <= '0;   iss_done_q <= 1'b0;
      infl_q <= 1'b0;     infl_last_q <= 1'b0; sk_data_q <= '0;
      sk_last_q <= '0;    sk_cnt_q <= '0;
    end else begin
      state_q <= state_d;       mode_q <= mode_d;          sel_q <= sel_d;
      pb_len_q <= pb_len_d;     post_cnt_q <= post_cnt_d;  wr_ptr_q <= wr_ptr_d;
      wrapped_q <= wrapped_d;   trig_seen_q <= trig_seen_d; trig_addr_q <= trig_addr_d;
      rd_valid_q <= rd_valid_d; pb_addr_q <= pb_addr_d;    iss_done_q <= iss_done_d;
      infl_q <= infl_d;         infl_last_q <= infl_last_d; sk_data_q <= sk_data_d;
      sk_last_q <= sk_last_d;   sk_cnt_q <= sk_cnt_d;
    end
  end

  assign state     = state_q;
  assign wr_ptr    = wr_ptr_q;
  assign wrapped   = wrapped_q;
  assign trig_seen = trig_seen_q;
  assign trig_addr = trig_addr_q;
  assign rd_data   = rdat_q;
  assign rd_valid  = rd_valid_q;
  assign pb_data   = sk_data_q[0];
  assign pb_valid  = (sk_cnt_q != 2'd0);
endmodule

// File: tb/tb_fm_spy_ring.sv
// Directed-plus-random bench for fm_spy_ring (ADDR_WIDTH=4, 4 channels).
// A 16-entry array mirrors what the memory should hold; playback and readout
// are compared against it.
module tb_fm_spy_ring;
  localparam int DW = 64, AW = 4, NC = 4, PW = 10;

  logic            clk_hs = 1'b0, rst_hs = 1'b0;
  logic [NC*DW-1:0] ch_data = '0;
  logic [NC-1:0]   ch_valid = '0;
  logic [1:0]      ch_sel = '0, mode = '0;
  logic            start = 0, stop = 0, trigger = 0, rd_en = 0, pb_ready = 0;
  logic [PW-1:0]   post_trig = '0;
  logic [AW-1:0]   pb_len = '0, rd_addr = '0;
  logic [DW-1:0]   rd_data, pb_data;
  logic            rd_valid, pb_valid, wrapped, trig_seen;
  logic [2:0]      state;
  logic [AW-1:0]   wr_ptr, trig_addr;

  fm_spy_ring #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_CH(NC), .POST_W(PW)) dut (
    .clk_hs(clk_hs), .rst_hs(rst_hs), .ch_data(ch_data), .ch_valid(ch_valid),
    .ch_sel(ch_sel), .mode(mode), .start(start), .stop(stop), .trigger(trigger),
    .post_trig(post_trig), .pb_len(pb_len), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .pb_data(pb_data), .pb_valid(pb_valid),
    .pb_ready(pb_ready), .state(state), .wr_ptr(wr_ptr), .wrapped(wrapped),
    .trig_seen(trig_seen), .trig_addr(trig_addr));

  always #5 clk_hs = ~clk_hs;

  int vectors = 0, miscompares = 0;
  logic [DW-1:0] ref_mem [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_hs); #1;
  endtask

  // Drive channel 2 with d (valid if v); the other channels carry 0xDEAD.
  task automatic set_ch(input logic v, input logic [DW-1:0] d);
    for (int k = 0; k < NC; k++) ch_data[k*DW +: DW] = 64'hDEAD;
    ch_data[2*DW +: DW] = d;
    ch_valid = v ? 4'hF : 4'hB;
  endtask

  task automatic rand_gaps;
    while ($urandom_range(0, 3) == 0) begin set_ch(1'b0, 64'h0); tick; end
  endtask

  task automatic rd_chk(input int a);
    rd_en = 1; rd_addr = AW'(a); tick;
    chk("rd_valid", 64'(rd_valid), 64'd1);
    chk($sformatf("rd_data[%0d]", a), rd_data, ref_mem[a]);
  endtask

  task automatic cmd_start(input logic [1:0] m);
    mode = m; start = 1; tick; start = 0;
  endtask

  // Run playback with random backpressure until n words have transferred.
  task automatic pb_run(input int n, input int len);
    int idx = 0;
    logic stall = 0, pr;
    logic [DW-1:0] held = '0;
    rd_en = 1;
    for (int g = 0; g < 300 && idx < n; g++) begin
      if (stall) chk("pb_hold", pb_data, held);
      chk("pb_rd_ignored", 64'(rd_valid), 64'd0);
      pr = 1'($urandom_range(0, 1)); pb_ready = pr;
      if (pb_valid) begin
        chk($sformatf("pb_data#%0d", idx), pb_data, ref_mem[idx % (len + 1)]);
        held = pb_data; stall = !pr;
        if (pr) idx++;
      end else begin
        chk("pb_no_drop", 64'(stall), 64'd0);
        stall = 0;
      end
      tick;
    end
    rd_en = 0; pb_ready = 0;
    chk("pb_count", 64'(idx), 64'(n));
  endtask

  initial begin
    logic [DW-1:0] d;
    // Reset state
    #3;
    chk("rst_state", 64'(state), 0);     chk("rst_wr_ptr", 64'(wr_ptr), 0);
    chk("rst_wrapped", 64'(wrapped), 0); chk("rst_trig_seen", 64'(trig_seen), 0);
    chk("rst_rd_valid", 64'(rd_valid), 0); chk("rst_pb_valid", 64'(pb_valid), 0);
    chk("rst_rd_data", rd_data, 0);
    repeat (2) @(posedge clk_hs);
    #3 rst_hs = 1;
    tick;

    // SPY capture of 20 words on channel 2, wraps once
    ch_sel = 2'd2;
    cmd_start(2'd0);
    chk("spy_state", 64'(state), 1);
    for (int i = 0; i < 20; i++) begin
      rand_gaps;
      set_ch(1'b1, 64'(i)); tick;
      ref_mem[i % 16] = 64'(i);
    end
    set_ch(1'b0, 64'h0);
    stop = 1; tick; stop = 0;
    chk("spy_wr_ptr", 64'(wr_ptr), 4);
    chk("spy_wrapped", 64'(wrapped), 1);
    chk("spy_state_frozen", 64'(state), 3);
    for (int a = 0; a < 16; a++) rd_chk(a);
    rd_en = 0;
    chk("spy_top_value", ref_mem[0], 64'd16);

    // FREEZE_ON_TRIG, post_trig=3, trigger with word 5
    post_trig = 10'd3;
    cmd_start(2'd1);
    for (int i = 0; i < 12; i++) begin
      rand_gaps;
      d = {$urandom, $urandom};
      set_ch(1'b1, d); trigger = (i == 5); tick; trigger = 0;
      if (i <= 5 + 3) ref_mem[i] = d;
      if (i == 5) chk("trig_post_state", 64'(state), 2);
    end
    set_ch(1'b0, 64'h0);
    chk("trig_state", 64'(state), 3);
    chk("trig_addr", 64'(trig_addr), 5);
    chk("trig_seen", 64'(trig_seen), 1);
    chk("trig_wr_ptr", 64'(wr_ptr), 9);
    for (int a = 4; a < 11; a++) rd_chk(a);
    rd_en = 0;

    // FREEZE_ON_TRIG, post_trig=0, trigger on an idle cycle at wr_ptr=7
    post_trig = '0;
    cmd_start(2'd1);
    for (int i = 0; i < 7; i++) begin
      rand_gaps;
      d = {$urandom, $urandom};
      set_ch(1'b1, d); tick; ref_mem[i] = d;
    end
    set_ch(1'b0, 64'h0);
    trigger = 1; tick; trigger = 0;
    chk("trig0_state", 64'(state), 3);
    chk("trig0_addr", 64'(trig_addr), 7);
    chk("trig0_wr_ptr", 64'(wr_ptr), 7);
    rd_chk(7); rd_chk(6);
    rd_en = 0;

    // PB_ONCE, pb_len=3
    pb_len = 4'd3;
    cmd_start(2'd2);
    chk("pb_state", 64'(state), 4);
    chk("pb_valid_t1", 64'(pb_valid), 0);
    tick;
    chk("pb_valid_t1b", 64'(pb_valid), 0);
    tick;
    chk("pb_valid_t2", 64'(pb_valid), 1);
    chk("pb_first", pb_data, ref_mem[0]);
    pb_run(4, 3);
    chk("pb_once_idle", 64'(state), 0);
    chk("pb_once_valid", 64'(pb_valid), 0);
    repeat (3) begin tick; chk("pb_once_nodup", 64'(pb_valid), 0); end

    // PB_LOOP, pb_len=1, then stop
    pb_len = 4'd1;
    cmd_start(2'd3);
    pb_run(7, 1);
    stop = 1; tick; stop = 0;
    chk("loop_stop_valid", 64'(pb_valid), 0);
    chk("loop_stop_state", 64'(state), 0);
    start = 1; stop = 1; tick; start = 0; stop = 0;
    chk("start_stop_idle", 64'(state), 0);

    // Async reset in mid-POST
    post_trig = 10'd5;
    cmd_start(2'd1);
    for (int i = 0; i < 4; i++) begin
      d = {$urandom, $urandom};
      set_ch(1'b1, d); trigger = (i == 2);
      if (i == 3) begin rd_en = 1; rd_addr = 4'd9; end
      tick; trigger = 0; ref_mem[i] = d;
    end
    set_ch(1'b0, 64'h0); rd_en = 0;
    chk("pre_rst_state", 64'(state), 2);
    chk("pre_rst_rd_valid", 64'(rd_valid), 1);
    #2 rst_hs = 0;
    #1;
    chk("arst_state", 64'(state), 0);     chk("arst_wr_ptr", 64'(wr_ptr), 0);
    chk("arst_trig_seen", 64'(trig_seen), 0); chk("arst_rd_valid", 64'(rd_valid), 0);
    chk("arst_pb_valid", 64'(pb_valid), 0);
    #2 rst_hs = 1;
    tick;
    cmd_start(2'd0);
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom};
      set_ch(1'b1, d); tick; ref_mem[i] = d;
    end
    set_ch(1'b0, 64'h0);
    stop = 1; tick; stop = 0;
    chk("restart_wr_ptr", 64'(wr_ptr), 3);
    chk("restart_wrapped", 64'(wrapped), 0);
    chk("restart_state", 64'(state), 3);
    for (int a = 0; a < 3; a++) rd_chk(a);
    rd_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fm_spy_ring.md
# fm_spy_ring

Parametrised single-clock spy ring buffer for the fast-monitoring (FM) path. It captures one selectable channel of `clk_hs` monitor data into a circular memory, either continuously or frozen a programmable number of words after a trigger. It supports random-access readout and a ready/valid playback stream that runs once or in a loop. It generalises the fixed spy-buffer/freeze/playback behaviour of the FM spy memories with the following additions: N input channels, programmable depth, post-trigger freeze and a handshaked playback output.

## Interface
- `DATA_WIDTH`, 64, width of one captured word
- `ADDR_WIDTH`, 10, memory depth = 2**ADDR_WIDTH words
- `N_CH`, 4, number of input channels (≥1); `SEL_W` = max(1, $clog2(N_CH))
- `POST_W`, 10, width of post-trigger count
- `clk_hs`  in  1  single clock for all logic
- `rst_hs`  in  1  asynchronous, active-low reset
- `ch_data`  in  N_CH*DATA_WIDTH  packed channel data; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- `ch_valid`  in  N_CH  per-channel word valid
- `ch_sel`  in  SEL_W  capture channel; latched on accepted `start`
- `mode`  in  2  0=SPY, 1=FREEZE_ON_TRIG, 2=PB_ONCE, 3=PB_LOOP; latched on accepted `start`
- `start`  in  1  one-cycle command pulse
- `stop`  in  1  one-cycle command pulse
- `trigger`  in  1  freeze trigger, level-sampled
- `post_trig`  in  POST_W  words to write after trigger; latched on trigger
- `pb_len`  in  ADDR_WIDTH  playback length minus 1; latched on accepted `start`
- `rd_en` / `rd_addr`  in  1 / ADDR_WIDTH  random-access read request
- `rd_data` / `rd_valid`  out  DATA_WIDTH / 1  read response
- `pb_data` / `pb_valid`  out  DATA_WIDTH / 1  playback stream
- `pb_ready`  in  1  playback sink ready
- `state`  out  3  0=IDLE, 1=CAPTURE, 2=POST, 3=FROZEN, 4=PLAYBACK
- `wr_ptr`  out  ADDR_WIDTH  next write address
- `wrapped`  out  1  the write pointer has passed the top address since the last capture start
- `trig_seen` / `trig_addr`  out  1 / ADDR_WIDTH  trigger recorded and its address

## Operation
- Reset: all outputs are 0 and `state` is IDLE. Memory contents are not cleared.
- The memory has one write port and one read port, with read-first behaviour on the same address.
- `start` is accepted in IDLE and FROZEN only.
  - For modes 0/1 it clears `wr_ptr`, `wrapped` and `trig_seen`, then enters CAPTURE.
  - For modes 2/3 it clears the playback pointer and enters PLAYBACK.
- `stop` overrides `start` when both are asserted in the same cycle.
- CAPTURE:
  - Each cycle with `ch_valid[sel]` high, write `ch_data[sel]` to `mem[wr_ptr]` and increment `wr_ptr` modulo the depth. The transition from top address to 0 sets `wrapped`.
  - `trigger` in mode 1 sets `trig_seen` and `trig_addr` to the current `wr_ptr` (the address of this cycle's write, if any).
    - `post_trig`=0: go to FROZEN; the trigger-cycle word is still written.
    - Otherwise: go to POST with count = `post_trig`.
  - `trigger` is ignored in mode 0.
  - `stop` goes to FROZEN; that cycle's write still occurs. If `trigger` is asserted in the same cycle, it is still recorded.
- POST:
  - Writes continue; each written word decrements the count.
  - The write that takes the count to 0 moves the block to FROZEN.
  - `trigger` is ignored; `stop` goes to FROZEN.
- FROZEN: no writes. `stop` goes to IDLE.
- PLAYBACK:
  - Stream `mem[0..pb_len]` on `pb_data` in address order.
  - A word is transferred on `pb_valid && pb_ready`. `pb_data` is held stable while `pb_valid && !pb_ready`, which needs a 2-entry skid to cover the read latency.
  - After the transfer of word `pb_len`:
    - PB_ONCE: go to IDLE.
    - PB_LOOP: continue from address 0 with no bubble required.
  - `stop` goes to IDLE and clears any in-flight words; `pb_valid` is 0 from the next cycle.
  - No capture writes occur.
- Readout: `rd_en` is serviced in every state except PLAYBACK, where it is ignored and `rd_valid` stays 0.

## Timing
- Commands are sampled at the `clk_hs` edge, and `state` updates on that edge. The first capture write can occur in the first cycle `state`=CAPTURE.
- `wr_ptr` and `wrapped` update on the edge of the write.
- `rd_data` and `rd_valid` appear 1 cycle after `rd_en`. Back-to-back reads are supported at 1 per cycle.
- `pb_valid` first rises 2 cycles after the `start` edge. Sustained throughput is 1 word per cycle with `pb_ready` held high.
- Asynchronous reset assertion clears all outputs immediately, including in mid-POST and mid-PLAYBACK. Deassertion is synchronised by the integrating logic.

## Test plan
- ADDR_WIDTH=4, mode 0, `ch_sel`=2: write words 0..19 on channel 2, with other channels valid carrying 0xDEAD, then `stop` → `wr_ptr`=4, `wrapped`=1, `state`=FROZEN. Reading addresses 0..3 returns 16..19, and addresses 4..15 return 4..15.
- Mode 1, `post_trig`=3, `trigger` with word 5 → `trig_addr`=5, `trig_seen`=1. FROZEN is reached after word 8 is written, `wr_ptr`=9, and later valid words are not written (address 9 keeps its old value).
- Mode 1, `post_trig`=0, trigger on an idle cycle with `wr_ptr`=7 → FROZEN next edge, `trig_addr`=7.
- PB_ONCE, `pb_len`=3, random `pb_ready` at 50% → exactly `mem[0..3]` are transferred in order with no duplicates, `pb_data` is stable under backpressure, then `state`=IDLE and `pb_valid`=0.
- PB_LOOP, `pb_len`=1 → transfers alternate mem[0],mem[1],mem[0]... After `stop`, `pb_valid`=0 next cycle and `state`=IDLE. `start` and `stop` in the same cycle from IDLE → remains IDLE.
- Assert `rst_hs`=0 mid-POST → `state`, `wr_ptr`, `trig_seen`, `rd_valid` and `pb_valid` are 0 without a clock edge. A restart then captures normally from address 0.
